music_sequencer: RTL and testbench
==================================

MUSIC_SEQUENCER -- requirements
Module: music_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_SONGS, default 3, the number of selectable songs (2..8).
REQ-002 The block SHALL have parameter SONG_LEN, default 16, the notes per song (power of two, 2..64).
REQ-003 The block SHALL have parameter DIV_W, default 16, the width of a note half-period in clk cycles.
REQ-004 The block SHALL have parameter NOTE_TICKS, default 250000, the clk cycles per note slot, including the gap.
REQ-005 The block SHALL have parameter GAP_TICKS, default 2500, the silent clk cycles at the end of each slot (less than NOTE_TICKS).
REQ-006 The block SHALL have parameter DEB_CYC, default 20000, the key debounce stability window in cycles.
REQ-007 clk  in  1  the single system clock; all state is on its rising edge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 key_in  in  1  raw mode key, active-low, asynchronous to clk.
REQ-010 play_en  in  1  level; 1 = play, 0 = stop.
REQ-011 cfg_we  in  1  note-table write strobe, one cycle per write.
REQ-012 cfg_song  in  clog2(NUM_SONGS)  song index for the write.
REQ-013 cfg_addr  in  clog2(SONG_LEN)  note index for the write.
REQ-014 cfg_period  in  DIV_W  half-period value; 0 = rest.
REQ-015 tone_out  out  1  square-wave audio output.
REQ-016 led_mode  out  NUM_SONGS  one-hot current-song indicator.
REQ-017 note_idx  out  clog2(SONG_LEN)  index of the note being played.
REQ-018 busy  out  1  high in PLAY or GAP state.

Function
REQ-019 key_in SHALL pass through a 2-flop synchroniser, then a debouncer that accepts a new level only after DEB_CYC consecutive equal samples.
REQ-020 A debounced high-to-low transition SHALL produce a one-cycle press pulse.
REQ-021 Each press SHALL advance the song index by 1, wrapping from NUM_SONGS-1 to 0.
REQ-022 led_mode SHALL equal 1<<song on the cycle after the song index updates.
REQ-023 The note table SHALL hold NUM_SONGS*SONG_LEN entries of DIV_W bits.
REQ-024 When cfg_we=1, the table SHALL write cfg_period at [cfg_song][cfg_addr] at that clock edge.
REQ-025 A write to the entry currently sounding SHALL take effect at the next note load only.
REQ-026 The FSM SHALL have three states: IDLE, PLAY, GAP.
REQ-027 IDLE to PLAY: when play_en=1, load note 0 of the current song and clear the slot counter.
REQ-028 PLAY to GAP: when the slot counter reaches NOTE_TICKS-GAP_TICKS-1.
REQ-029 GAP to PLAY: when the slot counter reaches NOTE_TICKS-1; increment note_idx and load that note.
REQ-030 In PLAY with period P>0, a tone counter SHALL toggle tone_out every P cycles, giving f = clk/(2P); a period of 0 SHALL hold tone_out at 0.
REQ-031 On every note load the tone counter and tone_out SHALL clear, so each note starts from phase 0.
REQ-032 In GAP and IDLE, tone_out SHALL be 0.
REQ-033 play_en=0 in any state SHALL force IDLE on the next edge, with tone_out=0 and note_idx=0.
REQ-034 A press while busy SHALL switch the song and restart at note 0 in PLAY on the next edge, with the slot counter cleared.
REQ-035 If a press and the end of the last slot occur in the same cycle, the press SHALL take priority.

Reset
REQ-036 While rst_n=0: state=IDLE, song=0, led_mode=1, note_idx=0, tone_out=0, busy=0, debounced level=1, all counters=0.
REQ-037 Note-table contents SHALL NOT be reset.
REQ-038 Reset assertion mid-note SHALL silence tone_out asynchronously.

Configuration
REQ-039 The macro MUSIC_LOOP_EN SHALL control end-of-song behaviour.
REQ-040 With MUSIC_LOOP_EN defined: GAP of note SONG_LEN-1 SHALL go to PLAY with note_idx=0, repeating while play_en=1.
REQ-041 Without MUSIC_LOOP_EN: GAP of note SONG_LEN-1 SHALL go to IDLE with busy=0, and SHALL stay there until play_en goes 0 then 1.

Verification
REQ-042 NOTE_TICKS=100, GAP_TICKS=10, table song0 = {5,0,3,...}, play_en=1 -> tone_out toggles every 5 cycles for 90 cycles, then 10 cycles low, then note 1 silent.
REQ-043 key_in low for DEB_CYC-1 cycles then high -> no song change; low for DEB_CYC+5 cycles -> led_mode changes 001->010 exactly once.
REQ-044 Three valid presses with NUM_SONGS=3 -> led_mode 001->010->100->001.
REQ-045 play_en dropped mid-note at cycle 40 -> IDLE at cycle 41, tone_out=0, note_idx=0.
REQ-046 SONG_LEN=4, run past note 3 -> with MUSIC_LOOP_EN, note_idx returns to 0 and busy stays 1; without it, busy=0 and tone_out=0.
REQ-047 cfg write to [0][current note] mid-note -> current pitch unchanged; new pitch heard on the next pass through that note.

Source files
------------

// File: rtl/music_sequencer.sv
// Note-table music sequencer: debounced mode key, per-song note table, IDLE/PLAY/GAP FSM.
// Define MUSIC_LOOP_EN to repeat the song; otherwise playback stops after the last note.
module music_sequencer #(
   parameter int NUM_SONGS  = 3,
   parameter int SONG_LEN   = 16,
   parameter int DIV_W      = 16,
   parameter int NOTE_TICKS = 250000,
   parameter int GAP_TICKS  = 2500,
   parameter int DEB_CYC    = 20000,
   localparam int SONG_W    = $clog2(NUM_SONGS),
   localparam int IDX_W     = $clog2(SONG_LEN)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              key_in,
   input  logic              play_en,
   input  logic              cfg_we,
   input  logic [SONG_W-1:0] cfg_song,
   input  logic [IDX_W-1:0]  cfg_addr,
   input  logic [DIV_W-1:0]  cfg_period,
   output logic              tone_out,
   output logic [NUM_SONGS-1:0] led_mode,
   output logic [IDX_W-1:0]  note_idx,
   output logic              busy,
   output logic [1:0]        dbg_state
);

   localparam int CNT_W = $clog2(NOTE_TICKS);
   localparam int DEB_W = $clog2(DEB_CYC + 1);
   localparam logic [CNT_W-1:0]     PLAY_END  = CNT_W'(NOTE_TICKS - GAP_TICKS - 1);
   localparam logic [CNT_W-1:0]     SLOT_END  = CNT_W'(NOTE_TICKS - 1);
   localparam logic [DEB_W-1:0]     DEB_LAST  = DEB_W'(DEB_CYC - 1);
   localparam logic [SONG_W-1:0]    LAST_SONG = SONG_W'(NUM_SONGS - 1);
   localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(SONG_LEN - 1);
   localparam logic [IDX_W-1:0]     IDX_ZERO  = '0;
   localparam logic [NUM_SONGS-1:0] LED_ONE   = NUM_SONGS'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PLAY = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   state_t              state;
   logic                key_meta;
   logic                key_sync;
   logic                deb_level;
   logic [DEB_W-1:0]    deb_cnt;
   logic                press;
   logic [SONG_W-1:0]   song;
   logic [SONG_W-1:0]   song_inc;
   logic [SONG_W-1:0]   load_song;
   logic [IDX_W-1:0]    idx_inc;
   logic [CNT_W-1:0]    slot_cnt;
   logic [DIV_W-1:0]    tone_cnt;
   logic [DIV_W-1:0]    cur_period;
   logic                song_done;
   logic [DIV_W-1:0]    note_tbl [NUM_SONGS*SONG_LEN];

   assign song_inc  = (song == LAST_SONG) ? '0 : song + SONG_W'(1);
   assign load_song = press ? song_inc : song;
   assign idx_inc   = note_idx + IDX_W'(1);
   assign busy      = (state != S_IDLE);
   assign dbg_state = state;

   // A press pulse fires only when the debounced level falls (key is active-low).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_meta  <= 1'b1;
         key_sync  <= 1'b1;
         deb_level <= 1'b1;
         deb_cnt   <= '0;
         press     <= 1'b0;
      end else begin
         key_meta <= key_in;
         key_sync <= key_meta;
         press    <= 1'b0;
         if (key_sync == deb_level) begin
            deb_cnt <= '0;
         end else if (deb_cnt == DEB_LAST) begin
            deb_level <= key_sync;
            deb_cnt   <= '0;
            press     <= ~key_sync;
         end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
         end
      end
   end

   // Table has no reset; cur_period holds a copy so writes to the sounding note wait for the next load.
   always_ff @(posedge clk) begin
      if (cfg_we && (cfg_song <= LAST_SONG))
         note_tbl[{cfg_song, cfg_addr}] <= cfg_period;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         song       <= '0;
         led_mode   <= LED_ONE;
         note_idx   <= '0;
         slot_cnt   <= '0;
         tone_cnt   <= '0;
         tone_out   <= 1'b0;
         cur_period <= '0;
         song_done  <= 1'b0;
      end else begin
         led_mode <= LED_ONE << song;
         if (press)
            song <= song_inc;

         if (!play_en) begin
            state     <= S_IDLE;
            note_idx  <= '0;
            slot_cnt  <= '0;
            tone_cnt  <= '0;
            tone_out  <= 1'b0;
            song_done <= 1'b0;
         end else if (press && (state != S_IDLE)) begin
            // Song change while playing outranks the end-of-slot transition.
            state      <= S_PLAY;
            note_idx   <= '0;
            slot_cnt   <= '0;
            tone_cnt   <= '0;
            tone_out   <= 1'b0;
            cur_period <= note_tbl[{load_song, IDX_ZERO}];
         end else begin
            case (state)
               S_IDLE: begin
                  if (!song_done) begin
                     state      <= S_PLAY;
                     note_idx   <= '0;
                     slot_cnt   <= '0;
                     tone_cnt   <= '0;
                     tone_out   <= 1'b0;
                     cur_period <= note_tbl[{load_song, IDX_ZERO}];
                  end
               end
               S_PLAY: begin
                  slot_cnt <= slot_cnt + CNT_W'(1);
                  if (slot_cnt == PLAY_END) begin
                     state    <= S_GAP;
                     tone_cnt <= '0;
                     tone_out <= 1'b0;
                  end else if (cur_period == '0) begin
                     tone_cnt <= '0;
                     tone_out <= 1'b0;
                  end else if (tone_cnt == cur_period - DIV_W'(1)) begin
                     tone_cnt <= '0;
                     tone_out <= ~tone_out;
                  end else begin
                     tone_cnt <= tone_cnt + DIV_W'(1);
                  end
               end
               S_GAP: begin
                  tone_out <= 1'b0;
                  if (slot_cnt != SLOT_END) begin
                     slot_cnt <= slot_cnt + CNT_W'(1);
                  end else if (note_idx == LAST_IDX) begin
`ifdef MUSIC_LOOP_EN
                     state      <= S_PLAY;
                     note_idx   <= '0;
                     slot_cnt   <= '0;
                     tone_cnt   <= '0;
                     cur_period <= note_tbl[{song, IDX_ZERO}];
`else
                     state     <= S_IDLE;
                     note_idx  <= '0;
                     slot_cnt  <= '0;
                     tone_cnt  <= '0;
                     song_done <= 1'b1;
`endif
                  end else begin
                     state      <= S_PLAY;
                     note_idx   <= idx_inc;
                     slot_cnt   <= '0;
                     tone_cnt   <= '0;
                     cur_period <= note_tbl[{song, idx_inc}];
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_music_sequencer.sv
// Directed bench for music_sequencer: small timing parameters, note-slot vector table
// plus hand sequences for debounce, song switching, end-of-song and reset behaviour.
module tb_music_sequencer;

   logic       clk;
   logic       rst_n;
   logic       key_in;
   logic       play_en;
   logic       cfg_we;
   logic [1:0] cfg_song;
   logic [1:0] cfg_addr;
   logic [7:0] cfg_period;
   logic       tone_out;
   logic [2:0] led_mode;
   logic [1:0] note_idx;
   logic       busy;
   logic [1:0] dbg_state;

   int n_vec = 0;
   int n_err = 0;

`ifdef MUSIC_LOOP_EN
   localparam logic LOOP = 1'b1;
`else
   localparam logic LOOP = 1'b0;
`endif

   typedef struct {
      int         cyc;
      logic       tone;
      logic [1:0] idx;
      logic       busy;
   } vec_t;

   vec_t vecs [23];

   music_sequencer #(
      .NUM_SONGS(3), .SONG_LEN(4), .DIV_W(8),
      .NOTE_TICKS(100), .GAP_TICKS(10), .DEB_CYC(8)
   ) dut (
      .clk(clk), .rst_n(rst_n), .key_in(key_in), .play_en(play_en),
      .cfg_we(cfg_we), .cfg_song(cfg_song), .cfg_addr(cfg_addr), .cfg_period(cfg_period),
      .tone_out(tone_out), .led_mode(led_mode), .note_idx(note_idx),
      .busy(busy), .dbg_state(dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cfg_write(input int s, input int a, input int p);
      cfg_song   = 2'(s);
      cfg_addr   = 2'(a);
      cfg_period = 8'(p);
      cfg_we     = 1'b1;
      tick(1);
      cfg_we     = 1'b0;
   endtask

   // Leaves the bench at cycle 0 of note 0 of the current song.
   task automatic restart_play();
      play_en = 1'b0;
      tick(1);
      play_en = 1'b1;
      tick(1);
   endtask

   task automatic press_key(input int hold);
      key_in = 1'b0;
      tick(hold);
      key_in = 1'b1;
      tick(20);
   endtask

   initial begin
      int cur;
      bit seen;
      rst_n      = 1'b0;
      key_in     = 1'b1;
      play_en    = 1'b0;
      cfg_we     = 1'b0;
      cfg_song   = '0;
      cfg_addr   = '0;
      cfg_period = '0;

      vecs[0]  = '{0,   1'b0, 2'd0, 1'b1};
      vecs[1]  = '{4,   1'b0, 2'd0, 1'b1};
      vecs[2]  = '{5,   1'b1, 2'd0, 1'b1};
      vecs[3]  = '{9,   1'b1, 2'd0, 1'b1};
      vecs[4]  = '{10,  1'b0, 2'd0, 1'b1};
      vecs[5]  = '{85,  1'b1, 2'd0, 1'b1};
      vecs[6]  = '{89,  1'b1, 2'd0, 1'b1};
      vecs[7]  = '{90,  1'b0, 2'd0, 1'b1};
      vecs[8]  = '{99,  1'b0, 2'd0, 1'b1};
      vecs[9]  = '{100, 1'b0, 2'd1, 1'b1};
      vecs[10] = '{150, 1'b0, 2'd1, 1'b1};
      vecs[11] = '{200, 1'b0, 2'd2, 1'b1};
      vecs[12] = '{202, 1'b0, 2'd2, 1'b1};
      vecs[13] = '{203, 1'b1, 2'd2, 1'b1};
      vecs[14] = '{206, 1'b0, 2'd2, 1'b1};
      vecs[15] = '{300, 1'b0, 2'd3, 1'b1};
      vecs[16] = '{307, 1'b1, 2'd3, 1'b1};
      vecs[17] = '{383, 1'b1, 2'd3, 1'b1};
      vecs[18] = '{390, 1'b0, 2'd3, 1'b1};
      vecs[19] = '{399, 1'b0, 2'd3, 1'b1};
      vecs[20] = '{400, 1'b0, 2'd0, LOOP};
      vecs[21] = '{405, LOOP, 2'd0, LOOP};
      vecs[22] = '{430, 1'b0, 2'd0, LOOP};

      tick(3);
      check("rst_tone", tone_out, 0);
      check("rst_led", led_mode, 3'b001);
      check("rst_idx", note_idx, 0);
      check("rst_busy", busy, 0);
      check("rst_state", dbg_state, 0);
      rst_n = 1'b1;
      tick(1);

      cfg_write(0, 0, 5); cfg_write(0, 1, 0); cfg_write(0, 2, 3); cfg_write(0, 3, 7);
      cfg_write(1, 0, 4); cfg_write(1, 1, 2); cfg_write(1, 2, 2); cfg_write(1, 3, 2);
      cfg_write(2, 0, 6); cfg_write(2, 1, 0); cfg_write(2, 2, 0); cfg_write(2, 3, 0);

      // Song 0 end to end, sampled at hand-picked slot cycles.
      restart_play();
      cur = 0;
      foreach (vecs[i]) begin
         tick(vecs[i].cyc - cur);
         cur = vecs[i].cyc;
         check($sformatf("v%0d_tone@%0d", i, cur), tone_out, vecs[i].tone);
         check($sformatf("v%0d_idx@%0d", i, cur), note_idx, vecs[i].idx);
         check($sformatf("v%0d_busy@%0d", i, cur), busy, vecs[i].busy);
      end

      // Stop, restart, then drop play_en mid-note.
      play_en = 1'b0;
      tick(1);
      check("stop_busy", busy, 0);
      play_en = 1'b1;
      tick(1);
      check("restart_busy", busy, 1);
      tick(240);
      check("mid_idx", note_idx, 2);
      check("mid_tone", tone_out, 1);
      play_en = 1'b0;
      tick(1);
      check("drop_busy", busy, 0);
      check("drop_tone", tone_out, 0);
      check("drop_idx", note_idx, 0);

      // Debounce window and song wrap-around.
      press_key(7);
      check("deb_short_led", led_mode, 3'b001);
      press_key(13);
      check("deb_long_led", led_mode, 3'b010);
      tick(20);
      check("deb_single_led", led_mode, 3'b010);
      press_key(13);
      check("press2_led", led_mode, 3'b100);
      press_key(13);
      check("press3_led", led_mode, 3'b001);

      // Rewrite the sounding entry: old pitch continues, new pitch on next load.
      restart_play();
      tick(20);
      cfg_write(0, 0, 2);
      tick(4);
      check("cfg_old_pitch", tone_out, 1);
      restart_play();
      tick(2);
      check("cfg_new_pitch_hi", tone_out, 1);
      tick(2);
      check("cfg_new_pitch_lo", tone_out, 0);

      // Press while busy restarts song 1 at note 0.
      tick(146);
      check("pre_press_idx", note_idx, 1);
      key_in = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         tick(1);
         if (led_mode == 3'b010) seen = 1'b1;
      end
      check("press_busy_led", led_mode, 3'b010);
      check("press_busy_idx", note_idx, 0);
      check("press_busy_busy", busy, 1);
      check("press_busy_tone1", tone_out, 0);
      tick(3);
      check("press_busy_tone4", tone_out, 1);
      tick(4);
      check("press_busy_tone8", tone_out, 0);
      key_in = 1'b1;
      tick(20);

      // Press lands on the final edge of the last slot: the switch wins.
      restart_play();
      tick(389);
      key_in = 1'b0;
      tick(16);
      check("end_press_busy", busy, 1);
      check("end_press_idx", note_idx, 0);
      check("end_press_led", led_mode, 3'b100);
      key_in = 1'b1;
      tick(20);

      // Asynchronous reset mid-note, then table contents survive.
      restart_play();
      tick(7);
      check("pre_rst_tone", tone_out, 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_tone", tone_out, 0);
      check("async_rst_led", led_mode, 3'b001);
      check("async_rst_busy", busy, 0);
      tick(2);
      rst_n = 1'b1;
      tick(1);
      check("post_rst_busy", busy, 1);
      tick(2);
      check("post_rst_tone", tone_out, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
